// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift unit: shift directions, request decode
// and the shift-count/threshold decode where a zero field means a full word.
package pio_pkg;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_IN,
    OP_OUT,
    OP_PUSH,
    OP_PULL,
    OP_ISR_SET,
    OP_OSR_SET
  } op_e;

  // A zero count or threshold field encodes the full register width.
  function automatic int decode_cnt(input int cnt, input int data_w);
    return (cnt == 0) ? data_w : cnt;
  endfunction

endpackage

// File: rtl/pio_barrel_shift.sv
// Combinational shift by n (1..DATA_W) in either direction. It fills from
// 'fill' and reports the bits that leave the register as 'spill', zero-extended.
module pio_barrel_shift
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] fill,
  input  logic [SH_W:0]     n,
  input  logic              dir,
  output logic [DATA_W-1:0] shifted,
  output logic [DATA_W-1:0] spill
);

  localparam logic [SH_W:0] FULL = (SH_W+1)'(DATA_W);

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] fill_m;
  logic [SH_W:0]     rem;

  // Shifts by a full DATA_W yield zero, so n == DATA_W needs no special case.
  always_comb begin
    mask   = ~({DATA_W{1'b1}} << n);
    fill_m = fill & mask;
    rem    = FULL - n;
    if (dir == SHIFT_RIGHT) begin
      shifted = (data >> n) | (fill_m << rem);
      spill   = data & mask;
    end else begin
      shifted = (data << n) | fill_m;
      spill   = data >> rem;
    end
  end

endmodule

// File: rtl/pio_shift_unit.sv
// ISR/OSR pair for one PIO state machine: IN/OUT shifting, autopush/autopull,
// PUSH/PULL, MOV loads and the RX/TX FIFO handshakes with combinational stall.
module pio_shift_unit
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              penable,
  input  logic              hold,
  input  logic              in_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SH_W-1:0]   in_cnt,
  input  logic              in_dir,
  input  logic              out_req,
  input  logic [SH_W-1:0]   out_cnt,
  input  logic              out_dir,
  output logic [DATA_W-1:0] out_data,
  input  logic              push_req,
  input  logic              pull_req,
  input  logic              block,
  input  logic [DATA_W-1:0] pull_x,
  input  logic              autopush,
  input  logic              autopull,
  input  logic [SH_W-1:0]   push_thresh,
  input  logic [SH_W-1:0]   pull_thresh,
  input  logic              isr_set,
  input  logic              osr_set,
  input  logic [DATA_W-1:0] set_val,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              stall,
  output logic [SH_W:0]     isr_count,
  output logic [SH_W:0]     osr_count
);

  localparam logic [SH_W:0] FULL = (SH_W+1)'(DATA_W);

  function automatic logic [SH_W:0] sat_add(input logic [SH_W:0] a, input logic [SH_W:0] b);
    logic [SH_W+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, FULL}) ? FULL : s[SH_W:0];
  endfunction

  logic [DATA_W-1:0] isr, osr, isr_d, osr_d;
  logic [SH_W:0]     isr_cnt_d, osr_cnt_d;
  logic [SH_W:0]     n_in, n_out, push_th, pull_th, in_sum, out_sum;
  logic [DATA_W-1:0] isr_sh, isr_spill_unused, osr_src, osr_sh, osr_spill;
  logic              en, adv, push_hit, pull_need;
  op_e               op;

  assign n_in    = (SH_W+1)'(decode_cnt(int'(in_cnt), DATA_W));
  assign n_out   = (SH_W+1)'(decode_cnt(int'(out_cnt), DATA_W));
  assign push_th = (SH_W+1)'(decode_cnt(int'(push_thresh), DATA_W));
  assign pull_th = (SH_W+1)'(decode_cnt(int'(pull_thresh), DATA_W));

  // reset_n folds into the enable so a stall in flight is dropped at once.
  assign en = penable & ~hold & reset_n;

  always_comb begin
    op = OP_NONE;
    if (in_req)        op = OP_IN;
    else if (out_req)  op = OP_OUT;
    else if (push_req) op = OP_PUSH;
    else if (pull_req) op = OP_PULL;
    else if (isr_set)  op = OP_ISR_SET;
    else if (osr_set)  op = OP_OSR_SET;
  end

  assign in_sum    = sat_add(isr_count, n_in);
  assign out_sum   = sat_add(osr_count, n_out);
  assign push_hit  = autopush & (in_sum >= push_th);
  assign pull_need = autopull & (osr_count >= pull_th);
  // Autopull refills and shifts in the same cycle, so the OSR shifter sees the FIFO head.
  assign osr_src   = pull_need ? tx_data : osr;

  pio_barrel_shift #(.DATA_W(DATA_W), .SH_W(SH_W)) u_isr_shift (
    .data    (isr),
    .fill    (in_data),
    .n       (n_in),
    .dir     (in_dir),
    .shifted (isr_sh),
    .spill   (isr_spill_unused)
  );

  pio_barrel_shift #(.DATA_W(DATA_W), .SH_W(SH_W)) u_osr_shift (
    .data    (osr_src),
    .fill    ('0),
    .n       (n_out),
    .dir     (out_dir),
    .shifted (osr_sh),
    .spill   (osr_spill)
  );

  assign out_data = (reset_n && op == OP_OUT && !(pull_need && !tx_valid)) ? osr_spill : '0;

  always_comb begin
    stall    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    case (op)
      OP_IN: if (push_hit) begin
        if (rx_ready) begin
          rx_valid = en;
          rx_data  = isr_sh;
        end else begin
          stall = en;
        end
      end
      OP_OUT: if (pull_need) begin
        if (tx_valid) tx_ready = en;
        else          stall    = en;
      end
      OP_PUSH: if (rx_ready) begin
        rx_valid = en;
        rx_data  = isr;
      end else begin
        stall = en & block;
      end
      OP_PULL: if (tx_valid) tx_ready = en;
               else          stall    = en & block;
      default: ;
    endcase
    if (!rx_valid) rx_data = '0;
  end

  assign adv = en & ~stall;

  always_comb begin
    isr_d     = isr;
    isr_cnt_d = isr_count;
    osr_d     = osr;
    osr_cnt_d = osr_count;
    case (op)
      OP_IN: if (push_hit) begin
        isr_d     = '0;
        isr_cnt_d = '0;
      end else begin
        isr_d     = isr_sh;
        isr_cnt_d = in_sum;
      end
      OP_OUT: begin
        osr_d     = osr_sh;
        osr_cnt_d = pull_need ? n_out : out_sum;
      end
      OP_PUSH: begin
        isr_d     = '0;
        isr_cnt_d = '0;
      end
      OP_PULL: begin
        osr_d     = tx_valid ? tx_data : pull_x;
        osr_cnt_d = '0;
      end
      OP_ISR_SET: begin
        isr_d     = set_val;
        isr_cnt_d = '0;
      end
      OP_OSR_SET: begin
        osr_d     = set_val;
        osr_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isr       <= '0;
      isr_count <= '0;
      osr       <= '0;
      osr_count <= FULL;
    end else if (adv) begin
      isr       <= isr_d;
      isr_count <= isr_cnt_d;
      osr       <= osr_d;
      osr_count <= osr_cnt_d;
    end
  end

endmodule

// File: doc/pio_shift_unit.md
Name: pio_shift_unit

Overview:
- Parametrised successor to the fixed 32-bit input/output shift registers inside the PIO state machine. Holds the ISR and OSR for one state machine, with configurable width and shift direction.
- Adds autopush/autopull with correct stall semantics, blocking/non-blocking PUSH/PULL, and valid/ready handshakes to the RX/TX FIFOs.
- The state machine drives one-cycle request strobes and receives a combinational stall.

Parameters:
- DATA_W, 32, ISR/OSR width; power of two, 8..64.
- SH_W, $clog2(DATA_W), width of shift-count/threshold fields. Value 0 encodes DATA_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- penable  in  1  divided clock enable; no state change when low
- hold  in  1  external stall (delay/wait); no state change when high
- in_req  in  1  IN instruction strobe
- in_data  in  DATA_W  IN source value
- in_cnt  in  SH_W  bits to shift in
- in_dir  in  1  ISR direction: 1 = right, 0 = left
- out_req  in  1  OUT instruction strobe
- out_cnt  in  SH_W  bits to shift out
- out_dir  in  1  OSR direction: 1 = right, 0 = left
- out_data  out  DATA_W  bits shifted out, zero-extended (combinational)
- push_req  in  1  explicit PUSH strobe
- pull_req  in  1  explicit PULL strobe
- block  in  1  PUSH/PULL block flag
- pull_x  in  DATA_W  X value loaded by non-blocking PULL on empty
- autopush  in  1  autopush enable
- autopull  in  1  autopull enable
- push_thresh  in  SH_W  autopush threshold
- pull_thresh  in  SH_W  autopull threshold
- isr_set  in  1  MOV ISR strobe
- osr_set  in  1  MOV OSR strobe
- set_val  in  DATA_W  MOV source value
- rx_valid  out  1  RX FIFO write
- rx_data  out  DATA_W  RX FIFO data
- rx_ready  in  1  RX FIFO not full
- tx_valid  in  1  TX FIFO not empty
- tx_data  in  DATA_W  TX FIFO head
- tx_ready  out  1  TX FIFO pop
- stall  out  1  request cannot complete this cycle
- isr_count  out  SH_W+1  valid bits in ISR
- osr_count  out  SH_W+1  bits consumed from OSR

Behaviour:
- Reset (async, reset_n low): isr = 0, isr_count = 0, osr = 0, osr_count = DATA_W (OSR empty). All outputs 0 except osr_count.
- Update condition: adv = penable & ~hold & ~stall.
  - All register updates occur on the clk edge only when adv.
  - rx_valid and tx_ready are combinational and qualified by penable & ~hold.
- Count decode: n = (cnt == 0) ? DATA_W : cnt. Thresholds use the same decode.
- IN, right shift: isr' = (isr >> n) | (in_data[n-1:0] << (DATA_W - n)).
- IN, left shift: isr' = (isr << n) | in_data[n-1:0].
- IN count: isr_count' = min(isr_count + n, DATA_W).
- IN with autopush, when isr_count' >= push_thresh:
  - rx_ready = 1: rx_valid = 1, rx_data = isr'; isr and isr_count cleared.
  - rx_ready = 0: stall = 1; nothing changes; retried every enabled cycle.
- OUT, right shift: out_data = osr[n-1:0]; osr' = osr >> n.
- OUT, left shift: out_data = osr[DATA_W-1 -: n]; osr' = osr << n.
- OUT count: osr_count' = min(osr_count + n, DATA_W).
- OUT with autopull, when osr_count >= pull_thresh before the shift:
  - tx_valid = 1: tx_ready = 1; the shift operates on tx_data instead of osr (load and shift in one cycle); osr_count' = n.
  - tx_valid = 0: stall = 1; no state change.
- OUT without autopull: shifts regardless of count; OSR exhaustion is not checked.
- PUSH:
  - rx_ready = 1: push isr, clear isr and count.
  - rx_ready = 0, block = 1: stall.
  - rx_ready = 0, block = 0: data dropped, isr and count still cleared, no stall.
- PULL:
  - tx_valid = 1: osr = tx_data, osr_count = 0, tx_ready = 1.
  - tx_valid = 0, block = 1: stall.
  - tx_valid = 0, block = 0: osr = pull_x, osr_count = 0.
- MOV: isr_set sets isr = set_val, isr_count = 0. osr_set sets osr = set_val, osr_count = 0.
- Exclusivity: at most one of in_req, out_req, push_req, pull_req, isr_set, osr_set is high per cycle. The bench asserts this; the DUT need not arbitrate.
- Stall gating: stall is only asserted while penable & ~hold & a request is pending.
- Reset mid-stall: the stall is abandoned and no FIFO transfer is issued.

Decomposition:
- Shared package pio_pkg holds:
  - direction constants SHIFT_LEFT = 0 and SHIFT_RIGHT = 1;
  - a function decode_cnt(cnt) returning n, shared by counts and thresholds.
- One natural sub-module: pio_barrel_shift. It is a parametrised combinational shift-in/shift-out by n in either direction and is instantiated twice (ISR, OSR).
- Handshake/stall logic stays in pio_shift_unit.

Test Plan:
- IN right, in_cnt = 8, in_data = 0xA5 four times, autopush off → isr = 0xA5A5A5A5, isr_count = 32.
- IN left, in_cnt = 4, push_thresh = 8, autopush on, in_data = 0x3 then 0xC, rx_ready = 1 → one rx_valid pulse with rx_data = 0x3C, then isr_count = 0.
- Same autopush case with rx_ready = 0 for 3 enabled cycles → stall high for 3 cycles with isr unchanged; push completes in the cycle rx_ready rises.
- OSR empty after reset, autopull on, pull_thresh = 0 (32), OUT right out_cnt = 8, tx_data = 0x12345678, tx_valid = 1 → tx_ready pulse, out_data = 0x78, osr = 0x00123456, osr_count = 8.
- PULL non-blocking with tx_valid = 0, pull_x = 0xDEADBEEF → osr = 0xDEADBEEF with no stall. PULL blocking with tx_valid = 0 → stall held until tx_valid.
- penable toggling every 3rd cycle with hold pulses during the IN/OUT sequences → state advances only on penable & ~hold. reset_n asserted mid-stall → all outputs return to reset values immediately (async).
